// File: rtl/jtag_reg_master.sv
// Command-level initiator for the 2-bit-IR virtual-JTAG register bridge.
// Drives a divided, gated tck plus tdi/ir/state flags and samples tdo.
module jtag_reg_master #(
  parameter int TCK_DIV = 2,
  parameter int GAP_TCK = 4,
  parameter int DRW     = 40
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        tck,
  output logic        tdi,
  input  logic        tdo,
  output logic [1:0]  ir_in,
  output logic        vs_cdr,
  output logic        vs_sdr,
  output logic        vs_udr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CDR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_UDR   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam int DIVW   = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int CNTMAX = (GAP_TCK > DRW) ? GAP_TCK : DRW;
  localparam int CNTW   = $clog2(CNTMAX);

  localparam logic [DIVW-1:0] DIV_RISE   = DIVW'(TCK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_END    = DIVW'(2 * TCK_DIV - 1);
  localparam logic [CNTW-1:0] SHIFT_LAST = CNTW'(DRW - 1);
  localparam logic [CNTW-1:0] GAP_LAST   = CNTW'(GAP_TCK - 1);

  logic [2:0]      state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            phase2_q, phase2_d;
  logic [7:0]      addr_q, addr_d;
  logic [DRW-1:0]  sr_q, sr_d;
  logic [DRW-1:0]  cap_q, cap_d;
  logic            tck_q, tck_d;
  logic            tdi_q, tdi_d;
  logic [1:0]      ir_q, ir_d;
  logic            cdr_q, cdr_d;
  logic            sdr_q, sdr_d;
  logic            udr_q, udr_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  // Every tck cycle starts with tck low; flags/tdi only move at that start edge,
  // and tdo is captured on the edge that raises tck (before the responder shifts).
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    phase2_d = phase2_q;
    addr_d   = addr_q;
    sr_d     = sr_q;
    cap_d    = cap_q;
    tck_d    = tck_q;
    tdi_d    = tdi_q;
    ir_d     = ir_q;
    cdr_d    = cdr_q;
    sdr_d    = sdr_q;
    udr_d    = udr_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          ready_d  = 1'b0;
          state_d  = S_CDR;
          div_d    = '0;
          cnt_d    = '0;
          tck_d    = 1'b0;
          write_d  = cmd_write;
          phase2_d = 1'b0;
          addr_d   = cmd_addr;
          sr_d     = {(cmd_write ? cmd_wdata : 32'h0), cmd_addr};
          ir_d     = cmd_write ? 2'b01 : 2'b10;
          cdr_d    = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_RISE) begin
          tck_d = 1'b1;
          if (state_q == S_SHIFT && phase2_q) cap_d = {tdo, cap_q[DRW-1:1]};
        end
        if (div_q == DIV_END) begin
          div_d = '0;
          tck_d = 1'b0;
          case (state_q)
            S_CDR: begin
              state_d = S_SHIFT;
              cnt_d   = '0;
              cdr_d   = 1'b0;
              sdr_d   = 1'b1;
              tdi_d   = sr_q[0];
              sr_d    = sr_q >> 1;
            end
            S_SHIFT: begin
              if (cnt_q == SHIFT_LAST) begin
                state_d = S_UDR;
                sdr_d   = 1'b0;
                udr_d   = 1'b1;
                tdi_d   = 1'b0;
              end else begin
                cnt_d = cnt_q + 1'b1;
                tdi_d = sr_q[0];
                sr_d  = sr_q >> 1;
              end
            end
            S_UDR: begin
              state_d = S_GAP;
              cnt_d   = '0;
              udr_d   = 1'b0;
            end
            S_GAP: begin
              if (cnt_q == GAP_LAST) begin
                cnt_d = '0;
                // A read needs a second pass: the first only latches the address.
                if (!write_q && !phase2_q) begin
                  phase2_d = 1'b1;
                  state_d  = S_CDR;
                  cdr_d    = 1'b1;
                  sr_d     = {32'h0, addr_q};
                end else begin
                  state_d  = S_RESP;
                  ir_d     = 2'b00;
                  rvalid_d = 1'b1;
                  rdata_d  = write_q ? 32'h0 : cap_q[DRW-1:8];
                  err_d    = !write_q && (cap_q[7:0] != addr_q);
                end
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      phase2_q <= 1'b0;
      addr_q   <= '0;
      sr_q     <= '0;
      cap_q    <= '0;
      tck_q    <= 1'b0;
      tdi_q    <= 1'b0;
      ir_q     <= 2'b00;
      cdr_q    <= 1'b0;
      sdr_q    <= 1'b0;
      udr_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      phase2_q <= phase2_d;
      addr_q   <= addr_d;
      sr_q     <= sr_d;
      cap_q    <= cap_d;
      tck_q    <= tck_d;
      tdi_q    <= tdi_d;
      ir_q     <= ir_d;
      cdr_q    <= cdr_d;
      sdr_q    <= sdr_d;
      udr_q    <= udr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign tck       = tck_q;
  assign tdi       = tdi_q;
  assign ir_in     = ir_q;
  assign vs_cdr    = cdr_q;
  assign vs_sdr    = sdr_q;
  assign vs_udr    = udr_q;

endmodule

// File: tb/tb_jtag_reg_master.sv
// Self-checking bench for jtag_reg_master with a behavioural vJTAG responder.
// Expected responses are queued when a command is issued and popped on rsp_valid.
module tb_jtag_reg_master;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        tck, tdi, tdo;
  logic [1:0]  ir_in;
  logic        vs_cdr, vs_sdr, vs_udr;

  jtag_reg_master #(.TCK_DIV(2), .GAP_TCK(4), .DRW(40)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_n = 0;
  int cdr_n = 0, sdr_n = 0, udr_n = 0;
  logic [39:0] tdi_bits = '0;

  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];

  always @(posedge clk_sys) begin
    cyc++;
    if (rsp_valid) rsp_n++;
  end

  always @(posedge tck) begin
    if (vs_cdr) cdr_n++;
    if (vs_sdr) begin
      if (sdr_n < 40) tdi_bits[sdr_n] = tdi;
      sdr_n++;
    end
    if (vs_udr) udr_n++;
  end

  // Responder model: captures on CDR, shifts on SDR rising edges, latches on UDR.
  logic [39:0] m_sr = '0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] cfg_in_w = 16'h0;
  logic [31:0] scratch = 32'h0;
  logic        status_done = 1'b0;
  logic        corrupt = 1'b0;

  assign tdo = m_sr[0];

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h01:   m_read = {16'h0, cfg_in_w};
      8'h03:   m_read = scratch;
      8'h10:   m_read = {31'h0, status_done};
      default: m_read = 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge tck) begin
    if (vs_cdr) begin
      m_sr <= {m_read(m_addr), (corrupt ? 8'h05 : m_addr)};
    end else if (vs_sdr) begin
      m_sr <= {tdi, m_sr[39:1]};
    end else if (vs_udr) begin
      m_addr <= m_sr[7:0];
      if (ir_in == 2'b01) begin
        if (m_sr[7:0] == 8'h01) cfg_in_w <= m_sr[23:8];
        if (m_sr[7:0] == 8'h03) scratch <= m_sr[39:8];
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clk_wait();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input logic hold,
                       output int acc);
    exp_t e;
    logic rdy;
    e.rdata = er;
    e.err = ee;
    sb.push_back(e);
    cdr_n = 0;
    sdr_n = 0;
    udr_n = 0;
    tdi_bits = '0;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 500 && acc < 0; i++) begin
      rdy = cmd_ready;
      clk_wait();
      if (rdy) acc = cyc;
    end
    if (!hold) cmd_valid = 1'b0;
    if (acc < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: command not accepted in 500 clks");
    end
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 1000 && rc < 0; i++) begin
      clk_wait();
      if (rsp_valid) rc = cyc;
    end
    if (rc < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL rsp_timeout: no rsp_valid within 1000 clks");
    end
  endtask

  task automatic test_reset();
    repeat (3) clk_wait();
    total++;
    if (tck !== 1'b0 || tdi !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_tck_tdi: got %b%b want 00", tck, tdi);
    end
    total++;
    if ({vs_cdr, vs_sdr, vs_udr} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 000", {vs_cdr, vs_sdr, vs_udr});
    end
    total++;
    if (ir_in !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_ir: got %b want 00", ir_in);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_rsp: got %b %h %b want 0 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready_low: got %b want 0", cmd_ready);
    end
    rst_sys_n = 1'b1;
    clk_wait();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_ready_high: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int acc, rc;
    exp_t e;
    issue(1'b1, 8'h01, 32'h00000080, 32'h0, 1'b0, 1'b0, acc);
    total++;
    if (ir_in !== 2'b01 || vs_cdr !== 1'b1) begin
      bad++; $display("[TB] FAIL write_ir: got ir=%b cdr=%b want 01 1", ir_in, vs_cdr);
    end
    wait_rsp(rc);
    if (rc >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rc - acc !== 184) begin
        bad++; $display("[TB] FAIL write_latency: got %0d want 184", rc - acc);
      end
      total++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        bad++; $display("[TB] FAIL write_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    total++;
    if (tdi_bits !== 40'h00_0000_8001) begin
      bad++; $display("[TB] FAIL write_tdi: got %h want 0000008001", tdi_bits);
    end
    total++;
    if (cdr_n !== 1 || sdr_n !== 40 || udr_n !== 1) begin
      bad++; $display("[TB] FAIL write_edges: got %0d/%0d/%0d want 1/40/1", cdr_n, sdr_n, udr_n);
    end
    total++;
    if (cfg_in_w !== 16'h0080) begin
      bad++; $display("[TB] FAIL write_model: got %h want 0080", cfg_in_w);
    end
    total++;
    if (ir_in !== 2'b00) begin
      bad++; $display("[TB] FAIL write_ir_idle: got %b want 00", ir_in);
    end
  endtask

  task automatic test_read(input logic [7:0] a, input logic [31:0] er, input logic ee,
                           input string tag);
    int acc, rc;
    exp_t e;
    issue(1'b0, a, 32'hFFFF_FFFF, er, ee, 1'b0, acc);
    total++;
    if (ir_in !== 2'b10) begin
      bad++; $display("[TB] FAIL %s_ir: got %b want 10", tag, ir_in);
    end
    wait_rsp(rc);
    if (rc >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rc - acc !== 368) begin
        bad++; $display("[TB] FAIL %s_latency: got %0d want 368", tag, rc - acc);
      end
      total++;
      if (rsp_rdata !== e.rdata) begin
        bad++; $display("[TB] FAIL %s_rdata: got %h want %h", tag, rsp_rdata, e.rdata);
      end
      total++;
      if (rsp_err !== e.err) begin
        bad++; $display("[TB] FAIL %s_err: got %b want %b", tag, rsp_err, e.err);
      end
    end
    total++;
    if (cdr_n !== 2 || sdr_n !== 80 || udr_n !== 2) begin
      bad++; $display("[TB] FAIL %s_edges: got %0d/%0d/%0d want 2/80/2", tag, cdr_n, sdr_n, udr_n);
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc2, rc, rc2;
    int ready_hi;
    exp_t e, e2;
    issue(1'b1, 8'h03, 32'h00000100, 32'h0, 1'b0, 1'b1, acc);
    cmd_write = 1'b0;
    e2.rdata = 32'h00000100;
    e2.err = 1'b0;
    sb.push_back(e2);
    ready_hi = 0;
    rc = -1;
    for (int i = 0; i < 1000 && rc < 0; i++) begin
      clk_wait();
      if (cmd_ready !== 1'b0) ready_hi++;
      if (rsp_valid) rc = cyc;
    end
    total++;
    if (rc < 0 || ready_hi != 0) begin
      bad++; $display("[TB] FAIL b2b_ready_low: rsp_cyc=%0d ready_high_clks=%0d want rsp and 0", rc, ready_hi);
    end
    if (rc >= 0) begin
      e = sb.pop_front();
      total++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err || rc - acc !== 184) begin
        bad++; $display("[TB] FAIL b2b_write: got %h/%b lat %0d want %h/%b lat 184",
                        rsp_rdata, rsp_err, rc - acc, e.rdata, e.err);
      end
    end
    clk_wait();
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_idle: got ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid);
    end
    clk_wait();
    acc2 = cyc;
    cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0 || ir_in !== 2'b10 || acc2 - rc !== 2) begin
      bad++; $display("[TB] FAIL b2b_accept: got ready=%b ir=%b gap=%0d want 0 10 2", cmd_ready, ir_in, acc2 - rc);
    end
    wait_rsp(rc2);
    if (rc2 >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        bad++; $display("[TB] FAIL b2b_read: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      total++;
      if (rc2 - acc2 !== 368) begin
        bad++; $display("[TB] FAIL b2b_read_latency: got %0d want 368", rc2 - acc2);
      end
    end
  endtask

  task automatic test_echo_error();
    corrupt = 1'b1;
    test_read(8'h02, 32'hDEADBEEF, 1'b1, "echo");
    corrupt = 1'b0;
  endtask

  task automatic test_abort();
    int acc, rc, rsp_before;
    exp_t e;
    issue(1'b1, 8'h01, 32'h00001234, 32'h0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 400 && sdr_n < 20; i++) @(posedge clk_sys);
    total++;
    if (sdr_n < 20) begin
      bad++; $display("[TB] FAIL abort_reach_shift: got %0d sdr rises want 20", sdr_n);
    end
    #3;
    rst_sys_n = 1'b0;
    #1;
    total++;
    if ({tck, tdi, vs_cdr, vs_sdr, vs_udr} !== 5'b0 || ir_in !== 2'b00) begin
      bad++; $display("[TB] FAIL abort_async: got %b ir=%b want 00000 ir=00",
                      {tck, tdi, vs_cdr, vs_sdr, vs_udr}, ir_in);
    end
    if (sb.size() > 0) e = sb.pop_front();
    rsp_before = rsp_n;
    repeat (5) clk_wait();
    rst_sys_n = 1'b1;
    repeat (250) clk_wait();
    total++;
    if (rsp_n !== rsp_before) begin
      bad++; $display("[TB] FAIL abort_no_rsp: got %0d pulses want 0", rsp_n - rsp_before);
    end
    total++;
    if (cfg_in_w !== 16'h0080) begin
      bad++; $display("[TB] FAIL abort_model: got %h want 0080", cfg_in_w);
    end
    issue(1'b1, 8'h01, 32'h000000AA, 32'h0, 1'b0, 1'b0, acc);
    wait_rsp(rc);
    if (rc >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rc - acc !== 184 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        bad++; $display("[TB] FAIL abort_recover: got lat %0d %h/%b want lat 184 %h/%b",
                        rc - acc, rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    total++;
    if (cfg_in_w !== 16'h00AA) begin
      bad++; $display("[TB] FAIL abort_recover_model: got %h want 00aa", cfg_in_w);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    status_done = 1'b1;
    test_read(8'h10, 32'h00000001, 1'b0, "read_status");
    test_read(8'h7F, 32'hDEADBEEF, 1'b0, "read_unmapped");
    test_back_to_back();
    test_echo_error();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
